// File: rtl/game_pkg.sv
// Shared pong definitions: match states, score/serve defaults and playfield geometry.
// Used by the match sequencer, ball controller and score overlay.
package game_pkg;

   localparam int unsigned SCORE_W         = 4;
   localparam int unsigned WIN_SCORE_DEF   = 5;
   localparam int unsigned SERVE_DELAY_DEF = 60;

   typedef enum logic [2:0] {
      MATCH_IDLE       = 3'd0,
      MATCH_SERVE_WAIT = 3'd1,
      MATCH_PLAY       = 3'd2,
      MATCH_POINT      = 3'd3,
      MATCH_GAME_OVER  = 3'd4
   } match_state_t;

   // Plain-vector aliases for blocks that keep state in logic [2:0] registers
   localparam logic [2:0] ST_IDLE       = MATCH_IDLE;
   localparam logic [2:0] ST_SERVE_WAIT = MATCH_SERVE_WAIT;
   localparam logic [2:0] ST_PLAY       = MATCH_PLAY;
   localparam logic [2:0] ST_POINT      = MATCH_POINT;
   localparam logic [2:0] ST_GAME_OVER  = MATCH_GAME_OVER;

   localparam int unsigned SCREEN_W     = 640;
   localparam int unsigned SCREEN_H     = 480;
   localparam int unsigned PAD_W        = 8;
   localparam int unsigned PAD_H        = 64;
   localparam int unsigned PAD_LEFT_X   = 16;
   localparam int unsigned PAD_RIGHT_X  = SCREEN_W - PAD_LEFT_X - PAD_W;
   localparam int unsigned BALL_SIZE    = 8;
   localparam int unsigned BALL_START_X = (SCREEN_W - BALL_SIZE) / 2;
   localparam int unsigned BALL_START_Y = (SCREEN_H - BALL_SIZE) / 2;

   function automatic logic score_reached(input logic [SCORE_W-1:0] score,
                                          input int unsigned       target);
      return score == SCORE_W'(target);
   endfunction

endpackage

// File: rtl/tick_countdown.sv
// Loadable down-counter advanced by a tick strobe; done pulses on the tick that ends the count.
// A load of zero finishes on the first tick.
module tick_countdown #(
   parameter int unsigned CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             tick,
   output logic             done
);

   logic [CNT_W-1:0] count_q, count_d;
   logic             last_step;

   assign last_step = (count_q <= CNT_W'(1));
   assign done      = tick & ~load & last_step;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_value;
      end else if (tick && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/match_sequencer.sv
// Pong match sequencer: serve countdown, rally gating, scoring and winner declaration.
// Drives the ball controller run/recentre controls and the overlay state/score outputs.
module match_sequencer
   import game_pkg::*;
#(
   parameter int unsigned WIN_SCORE         = WIN_SCORE_DEF,
   parameter int unsigned SERVE_DELAY_TICKS = SERVE_DELAY_DEF,
   parameter int unsigned CNT_W             = 7
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               timing_tick,
   input  logic               start_btn,
   input  logic               miss_left,
   input  logic               miss_right,
   output logic               ball_run,
   output logic               ball_reset,
   output logic               serve_right,
   output logic [SCORE_W-1:0] score_left,
   output logic [SCORE_W-1:0] score_right,
   output logic [2:0]         state_o,
   output logic               game_over,
   output logic               winner_left
);

   localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_DELAY_TICKS);

   logic [2:0]         state_q, state_d;
   logic [SCORE_W-1:0] score_left_q, score_left_d;
   logic [SCORE_W-1:0] score_right_q, score_right_d;
   logic               serve_right_q, serve_right_d;
   logic               winner_left_q, winner_left_d;
   logic               ball_reset_q, ball_reset_d;
   logic               start_q;
   logic               start_rise;
   logic               cd_load;
   logic               cd_tick;
   logic               cd_done;

   // Sampled even while rst is high so a button held through reset yields no edge
   always_ff @(posedge clk) begin
      start_q <= start_btn;
   end

   assign start_rise = start_btn & ~start_q;
   assign cd_tick    = timing_tick & (state_q == ST_SERVE_WAIT);

   tick_countdown #(
      .CNT_W (CNT_W)
   ) u_serve_countdown (
      .clk        (clk),
      .rst        (rst),
      .load       (cd_load),
      .load_value (SERVE_LOAD),
      .tick       (cd_tick),
      .done       (cd_done)
   );

   always_comb begin
      state_d       = state_q;
      score_left_d  = score_left_q;
      score_right_d = score_right_q;
      serve_right_d = serve_right_q;
      winner_left_d = winner_left_q;
      ball_reset_d  = 1'b0;
      cd_load       = 1'b0;

      case (state_q)
         ST_IDLE, ST_GAME_OVER: begin
            if (start_rise) begin
               score_left_d  = '0;
               score_right_d = '0;
               serve_right_d = 1'b1;
               ball_reset_d  = 1'b1;
               cd_load       = 1'b1;
               state_d       = ST_SERVE_WAIT;
            end
         end

         ST_SERVE_WAIT: begin
            if (cd_done) begin
               state_d = ST_PLAY;
            end
         end

         ST_PLAY: begin
            // A simultaneous double miss is a void point: replay without scoring
            if (miss_left && !miss_right) begin
               score_right_d = score_right_q + SCORE_W'(1);
               serve_right_d = 1'b0;
            end else if (miss_right && !miss_left) begin
               score_left_d  = score_left_q + SCORE_W'(1);
               serve_right_d = 1'b1;
            end
            if (miss_left || miss_right) begin
               state_d = ST_POINT;
            end
         end

         ST_POINT: begin
            if (score_reached(score_left_q, WIN_SCORE) ||
                score_reached(score_right_q, WIN_SCORE)) begin
               winner_left_d = score_reached(score_left_q, WIN_SCORE);
               state_d       = ST_GAME_OVER;
            end else begin
               ball_reset_d = 1'b1;
               cd_load      = 1'b1;
               state_d      = ST_SERVE_WAIT;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         score_left_q  <= '0;
         score_right_q <= '0;
         serve_right_q <= 1'b0;
         winner_left_q <= 1'b0;
         ball_reset_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         score_left_q  <= score_left_d;
         score_right_q <= score_right_d;
         serve_right_q <= serve_right_d;
         winner_left_q <= winner_left_d;
         ball_reset_q  <= ball_reset_d;
      end
   end

   assign ball_run    = (state_q == ST_PLAY);
   assign game_over   = (state_q == ST_GAME_OVER);
   assign ball_reset  = ball_reset_q;
   assign serve_right = serve_right_q;
   assign score_left  = score_left_q;
   assign score_right = score_right_q;
   assign winner_left = winner_left_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer with a per-cycle behavioural match model.
module tb_match_sequencer;

   localparam int unsigned WIN   = 2;
   localparam int unsigned DELAY = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       timing_tick = 1'b0;
   logic       start_btn = 1'b0;
   logic       miss_left = 1'b0;
   logic       miss_right = 1'b0;
   logic       ball_run, ball_reset, serve_right, game_over, winner_left;
   logic [3:0] score_left, score_right;
   logic [2:0] state_o;

   int compared = 0;
   int mismatched = 0;
   int tick_div = 0;

   // Behavioural model of the match
   bit m_valid = 1'b0;
   int m_state = 0;
   int m_sl = 0;
   int m_sr = 0;
   int m_frozen = 0;
   bit m_serve = 1'b0;
   bit m_winner = 1'b0;
   bit m_pulse = 1'b0;
   bit m_start_prev = 1'b0;

   match_sequencer #(
      .WIN_SCORE         (WIN),
      .SERVE_DELAY_TICKS (DELAY),
      .CNT_W             (7)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .timing_tick (timing_tick),
      .start_btn   (start_btn),
      .miss_left   (miss_left),
      .miss_right  (miss_right),
      .ball_run    (ball_run),
      .ball_reset  (ball_reset),
      .serve_right (serve_right),
      .score_left  (score_left),
      .score_right (score_right),
      .state_o     (state_o),
      .game_over   (game_over),
      .winner_left (winner_left)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      compared++;
      mismatched++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   task automatic model_step();
      bit rise;
      rise = start_btn && !m_start_prev;
      m_start_prev = start_btn;
      if (rst) begin
         m_state = 0; m_sl = 0; m_sr = 0; m_frozen = 0;
         m_serve = 0; m_winner = 0; m_pulse = 0; m_valid = 1;
         return;
      end
      m_pulse = 0;
      case (m_state)
         0, 4: if (rise) begin
            m_sl = 0; m_sr = 0; m_serve = 1; m_pulse = 1; m_frozen = DELAY; m_state = 1;
         end
         1: if (timing_tick) begin
            if (m_frozen <= 1) begin
               m_frozen = 0; m_state = 2;
            end else begin
               m_frozen--;
            end
         end
         2: if (miss_left || miss_right) begin
            if (!miss_right) begin
               m_sr++; m_serve = 0;
            end else if (!miss_left) begin
               m_sl++; m_serve = 1;
            end
            m_state = 3;
         end
         3: if (m_sl == WIN || m_sr == WIN) begin
            m_winner = (m_sl == WIN); m_state = 4;
         end else begin
            m_pulse = 1; m_frozen = DELAY; m_state = 1;
         end
         default: m_state = 0;
      endcase
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         check("m_state", state_o, m_state);
         check("m_score_left", score_left, m_sl);
         check("m_score_right", score_right, m_sr);
         check("m_ball_run", ball_run, (m_state == 2));
         check("m_ball_reset", ball_reset, m_pulse);
         check("m_serve_right", serve_right, m_serve);
         check("m_game_over", game_over, (m_state == 4));
         if (m_state == 4) check("m_winner_left", winner_left, m_winner);
      end
   end

   // One-clk tick every 10 clocks
   initial forever begin
      @(posedge clk);
      #1;
      tick_div++;
      timing_tick = (tick_div % 10 == 0);
   end

   task automatic press_start();
      @(posedge clk); #1 start_btn = 1'b1;
      @(posedge clk); #1 start_btn = 1'b0;
   endtask

   task automatic pulse_miss(input bit l, input bit r);
      @(posedge clk); #1 miss_left = l; miss_right = r;
      @(posedge clk); #1 miss_left = 1'b0; miss_right = 1'b0;
   endtask

   // Called on the first negedge in SERVE_WAIT; ball must stay frozen for DELAY ticks
   task automatic serve_wait(input bit exp_serve);
      int n;
      int guard;
      n = 0;
      guard = 0;
      check("frozen_run", ball_run, 0);
      if (timing_tick) n++;
      while (n < DELAY && guard < 200) begin
         @(negedge clk);
         guard++;
         check("frozen_run", ball_run, 0);
         check("serve_dir", serve_right, exp_serve);
         if (timing_tick) n++;
      end
      if (guard >= 200) timeout("serve_ticks");
      @(negedge clk);
      check("run_after_tick", ball_run, 1);
      check("play_state", state_o, 2);
   endtask

   task automatic score_point(input bit l, input bit r, input int sl, input int sr,
                              input bit serve);
      pulse_miss(l, r);
      @(negedge clk);
      check("point_state", state_o, 3);
      check("point_sl", score_left, sl);
      check("point_sr", score_right, sr);
      check("point_run", ball_run, 0);
      @(negedge clk);
      check("reserve_state", state_o, 1);
      check("reserve_pulse", ball_reset, 1);
      serve_wait(serve);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_state", state_o, 0);
      check("rst_sl", score_left, 0);
      check("rst_sr", score_right, 0);
      check("rst_run", ball_run, 0);
      check("rst_pulse", ball_reset, 0);
      check("rst_serve", serve_right, 0);
      check("rst_game_over", game_over, 0);

      press_start();
      @(negedge clk);
      check("start_state", state_o, 1);
      check("start_pulse", ball_reset, 1);
      check("start_serve", serve_right, 1);
      serve_wait(1'b1);
      check("serve_sl", score_left, 0);
      check("serve_sr", score_right, 0);

      score_point(1'b0, 1'b1, 1, 0, 1'b1);
      score_point(1'b1, 1'b0, 1, 1, 1'b0);
      score_point(1'b1, 1'b1, 1, 1, 1'b0);

      pulse_miss(1'b0, 1'b1);
      @(negedge clk);
      check("win_point_state", state_o, 3);
      check("win_sl", score_left, 2);
      @(negedge clk);
      check("go_state", state_o, 4);
      check("go_flag", game_over, 1);
      check("go_winner", winner_left, 1);
      check("go_run", ball_run, 0);
      check("go_pulse", ball_reset, 0);

      pulse_miss(1'b1, 1'b0);
      pulse_miss(1'b0, 1'b1);
      repeat (3) @(negedge clk);
      check("go_hold_sl", score_left, 2);
      check("go_hold_sr", score_right, 1);
      check("go_hold_state", state_o, 4);

      press_start();
      @(negedge clk);
      check("restart_state", state_o, 1);
      check("restart_sl", score_left, 0);
      check("restart_sr", score_right, 0);
      check("restart_serve", serve_right, 1);
      check("restart_pulse", ball_reset, 1);
      serve_wait(1'b1);

      score_point(1'b0, 1'b1, 1, 0, 1'b1);
      score_point(1'b1, 1'b0, 1, 1, 1'b0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_state", state_o, 0);
      check("midrst_sl", score_left, 0);
      check("midrst_sr", score_right, 0);
      check("midrst_run", ball_run, 0);
      check("midrst_pulse", ball_reset, 0);

      @(posedge clk); #1 start_btn = 1'b1; rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) @(negedge clk);
      check("held_idle", state_o, 0);
      @(posedge clk); #1 start_btn = 1'b0;
      repeat (2) @(negedge clk);
      check("released_idle", state_o, 0);
      press_start();
      @(negedge clk);
      check("repress_state", state_o, 1);
      check("repress_pulse", ball_reset, 1);
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
